// File: rtl/decode_stage_pkg.sv
// LC-3b decode definitions: opcode encodings, the link register index and the
// decoded control bundle shared by the decode stage and its scoreboard.
package decode_stage_pkg;

  localparam int NREG_DEF = 8;
  localparam int XLEN_DEF = 16;
  localparam int REG_W    = 3;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDW  = 4'h6;
  localparam logic [3:0] OP_STW  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_RSVA = 4'hA;
  localparam logic [3:0] OP_RSVB = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_SHF  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [REG_W-1:0] R7 = 3'd7;

  typedef struct packed {
    logic             ld_reg;
    logic             ld_cc;
    logic             use_sr1;
    logic             use_sr2;
    logic             use_cc;
    logic [REG_W-1:0] dr;
  } ctrl_t;

  // Stores carry their data register in the DR field, so SR2 is taken from IR[11:9].
  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_STB) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-file, writeback and execute-side signals of the decode stage.
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int XLEN = XLEN_DEF
);
  localparam int SELW = $clog2(NREG);

  logic            if_valid;
  logic [XLEN-1:0] if_ir;
  logic [XLEN-1:0] if_npc;
  logic            if_ready;
  logic            flush;

  logic [SELW-1:0] rf_sr1;
  logic [SELW-1:0] rf_sr2;
  logic [XLEN-1:0] rf_sr1_data;
  logic [XLEN-1:0] rf_sr2_data;

  logic            wb_we;
  logic [SELW-1:0] wb_dr;
  logic [XLEN-1:0] wb_data;
  logic            wb_cc_we;

  logic            de_valid;
  logic            de_ready;
  logic [XLEN-1:0] de_ir;
  logic [XLEN-1:0] de_npc;
  logic [XLEN-1:0] de_sr1_val;
  logic [XLEN-1:0] de_sr2_val;
  logic [SELW-1:0] de_dr;
  logic            de_ld_reg;
  logic            de_ld_cc;

  modport slave (
    input  if_valid, if_ir, if_npc, flush,
    input  rf_sr1_data, rf_sr2_data,
    input  wb_we, wb_dr, wb_data, wb_cc_we,
    input  de_ready,
    output if_ready, rf_sr1, rf_sr2,
    output de_valid, de_ir, de_npc, de_sr1_val, de_sr2_val, de_dr, de_ld_reg, de_ld_cc
  );

  modport master (
    output if_valid, if_ir, if_npc, flush,
    output rf_sr1_data, rf_sr2_data,
    output wb_we, wb_dr, wb_data, wb_cc_we,
    output de_ready,
    input  if_ready, rf_sr1, rf_sr2,
    input  de_valid, de_ir, de_npc, de_sr1_val, de_sr2_val, de_dr, de_ld_reg, de_ld_cc
  );

endinterface

// File: rtl/decode_stage_scoreboard.sv
// Pending-write tracker: one bit per architectural register plus one for NZP.
// Queries report an entry as free when writeback is clearing it this cycle.
module decode_scoreboard
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_reg,
  input  logic [$clog2(NREG)-1:0] set_dr,
  input  logic                    set_cc,
  input  logic                    clr_reg,
  input  logic [$clog2(NREG)-1:0] clr_dr,
  input  logic                    clr_cc,
  input  logic [$clog2(NREG)-1:0] q_sr1,
  input  logic [$clog2(NREG)-1:0] q_sr2,
  input  logic [$clog2(NREG)-1:0] q_dr,
  output logic                    sr1_busy,
  output logic                    sr2_busy,
  output logic                    dr_busy,
  output logic                    cc_busy
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] live;
  logic            cc_q;
  logic            cc_d;

  // Clear is applied before set so an issue and a writeback to the same entry leave it pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_reg) set_mask[set_dr] = 1'b1;
    if (clr_reg) clr_mask[clr_dr] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | set_mask;
    cc_d   = (cc_q & ~clr_cc) | set_cc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      cc_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cc_q   <= cc_d;
    end
  end

  assign live     = pend_q & ~clr_mask;
  assign sr1_busy = live[q_sr1];
  assign sr2_busy = live[q_sr2];
  assign dr_busy  = live[q_dr];
  assign cc_busy  = cc_q & ~clr_cc;

endmodule

// File: rtl/decode_stage.sv
// LC-3b decode stage: one-entry instruction latch, opcode decode, writeback bypass
// on the operand reads and scoreboard-gated issue toward execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  localparam int SELW = $clog2(NREG);

  logic            vld_p0;
  logic [XLEN-1:0] ir_p0;
  logic [XLEN-1:0] npc_p0;

  ctrl_t           ctrl;
  logic [SELW-1:0] sr1_sel;
  logic [SELW-1:0] sr2_sel;
  logic            sr1_busy;
  logic            sr2_busy;
  logic            dr_busy;
  logic            cc_busy;
  logic            stall;
  logic            issue;
  logic            handoff;
  logic            accept;
  logic            load;

  function automatic ctrl_t decode(input logic [XLEN-1:0] ir);
    ctrl_t c;
    c    = '0;
    c.dr = ir[11:9];
    case (ir[15:12])
      OP_ADD, OP_AND, OP_XOR: begin
        c.use_sr1 = 1'b1;
        c.use_sr2 = ~ir[5];
        c.ld_reg  = 1'b1;
        c.ld_cc   = 1'b1;
      end
      OP_SHF, OP_LDB, OP_LDW: begin
        c.use_sr1 = 1'b1;
        c.ld_reg  = 1'b1;
        c.ld_cc   = 1'b1;
      end
      OP_LEA: c.ld_reg = 1'b1;
      OP_STB, OP_STW: begin
        c.use_sr1 = 1'b1;
        c.use_sr2 = 1'b1;
      end
      OP_JMP: c.use_sr1 = 1'b1;
      OP_JSR: begin
        // IR[11]=0 is JSRR, which jumps through BaseR.
        c.use_sr1 = ~ir[11];
        c.ld_reg  = 1'b1;
        c.dr      = R7;
      end
      OP_TRAP: begin
        c.ld_reg = 1'b1;
        c.dr     = R7;
      end
      OP_BR: c.use_cc = |ir[11:9];
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] bypass(input logic [SELW-1:0] sel,
                                             input logic [XLEN-1:0] rf_data,
                                             input logic            we,
                                             input logic [SELW-1:0] dr,
                                             input logic [XLEN-1:0] data);
    return (we && (dr == sel)) ? data : rf_data;
  endfunction

  assign ctrl    = decode(ir_p0);
  assign sr1_sel = ir_p0[8:6];
  assign sr2_sel = is_store(ir_p0[15:12]) ? ir_p0[11:9] : ir_p0[2:0];

  decode_scoreboard #(.NREG(NREG)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_reg (handoff & ctrl.ld_reg),
    .set_dr  (ctrl.dr),
    .set_cc  (handoff & ctrl.ld_cc),
    .clr_reg (bus.wb_we),
    .clr_dr  (bus.wb_dr),
    .clr_cc  (bus.wb_cc_we),
    .q_sr1   (sr1_sel),
    .q_sr2   (sr2_sel),
    .q_dr    (ctrl.dr),
    .sr1_busy(sr1_busy),
    .sr2_busy(sr2_busy),
    .dr_busy (dr_busy),
    .cc_busy (cc_busy)
  );

  assign stall   = (ctrl.use_sr1 & sr1_busy) | (ctrl.use_sr2 & sr2_busy) |
                   (ctrl.ld_reg & dr_busy)   | (ctrl.use_cc & cc_busy);
  assign issue   = vld_p0 & ~stall & ~bus.flush;
  assign handoff = issue & bus.de_ready;
  assign accept  = ~vld_p0 | handoff;
  assign load    = bus.if_valid & accept & ~bus.flush;

  // p0: fetch -> decode latch; empties on handoff or flush, reloads on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      ir_p0  <= '0;
      npc_p0 <= '0;
    end else if (load) begin
      vld_p0 <= 1'b1;
      ir_p0  <= bus.if_ir;
      npc_p0 <= bus.if_npc;
    end else if (handoff || bus.flush) begin
      vld_p0 <= 1'b0;
    end
  end

  assign bus.if_ready   = accept;
  assign bus.rf_sr1     = sr1_sel;
  assign bus.rf_sr2     = sr2_sel;
  assign bus.de_valid   = issue;
  assign bus.de_ir      = ir_p0;
  assign bus.de_npc     = npc_p0;
  assign bus.de_dr      = ctrl.dr;
  assign bus.de_ld_reg  = ctrl.ld_reg;
  assign bus.de_ld_cc   = ctrl.ld_cc;
  assign bus.de_sr1_val = bypass(sr1_sel, bus.rf_sr1_data, bus.wb_we, bus.wb_dr, bus.wb_data);
  assign bus.de_sr2_val = bypass(sr2_sel, bus.rf_sr2_data, bus.wb_we, bus.wb_dr, bus.wb_data);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed hazard/flush/reset scenarios followed by random
// traffic, all checked against an instruction-level model of the stage.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit         w_reg;
    bit         w_cc;
    bit         r1;
    bit         r2;
    bit         rcc;
    logic [2:0] dr;
    logic [2:0] s1;
    logic [2:0] s2;
  } ref_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
  } fetch_t;

  logic [15:0] regs[8];
  bit          pend[8];
  bit          pcc;
  fetch_t      lat[$];
  ref_t        inflight[$];
  bit          mon_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  assign bus.rf_sr1_data = regs[bus.rf_sr1];
  assign bus.rf_sr2_data = regs[bus.rf_sr2];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // What each LC-3b opcode reads and writes.
  function automatic ref_t ref_decode(input logic [15:0] ir);
    ref_t r;
    r = '{default: '0};
    r.dr = ir[11:9];
    r.s1 = ir[8:6];
    r.s2 = ir[2:0];
    case (ir[15:12])
      4'd1, 4'd5, 4'd9: begin r.r1 = 1; r.r2 = !ir[5]; r.w_reg = 1; r.w_cc = 1; end
      4'd2, 4'd6, 4'd13: begin r.r1 = 1; r.w_reg = 1; r.w_cc = 1; end
      4'd14: r.w_reg = 1;
      4'd3, 4'd7: begin r.r1 = 1; r.r2 = 1; r.s2 = ir[11:9]; end
      4'd12: r.r1 = 1;
      4'd4: begin r.r1 = !ir[11]; r.w_reg = 1; r.dr = 3'd7; end
      4'd15: begin r.w_reg = 1; r.dr = 3'd7; end
      4'd0: r.rcc = (ir[11:9] != 3'd0);
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit busy(input logic [2:0] r);
    return pend[r] && !(bus.wb_we && bus.wb_dr == r);
  endfunction

  function automatic bit exp_valid();
    ref_t r;
    if (lat.size() == 0 || bus.flush) return 1'b0;
    r = ref_decode(lat[0].ir);
    if (r.r1 && busy(r.s1)) return 1'b0;
    if (r.r2 && busy(r.s2)) return 1'b0;
    if (r.w_reg && busy(r.dr)) return 1'b0;
    if (r.rcc && pcc && !bus.wb_cc_we) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] opnd(input logic [2:0] s);
    return (bus.wb_we && bus.wb_dr == s) ? bus.wb_data : regs[s];
  endfunction

  // Model state advance: writeback clears, issue sets, latch pops/flushes/loads.
  always @(posedge clk) begin
    bit   ev;
    bit   hand;
    bit   rdy;
    ref_t r;
    if (rst) begin
      lat.delete();
      inflight.delete();
      pcc = 0;
      for (int i = 0; i < 8; i++) pend[i] = 0;
    end else begin
      ev   = exp_valid();
      hand = ev && bus.de_ready;
      rdy  = (lat.size() == 0) || hand;
      if (bus.wb_we) pend[bus.wb_dr] = 0;
      if (bus.wb_cc_we) pcc = 0;
      if (hand) begin
        r = ref_decode(lat[0].ir);
        if (r.w_reg) pend[r.dr] = 1;
        if (r.w_cc) pcc = 1;
        if (r.w_reg || r.w_cc) inflight.push_back(r);
        void'(lat.pop_front());
      end else if (bus.flush) begin
        lat.delete();
      end
      if (bus.if_valid && rdy && !bus.flush) lat.push_back('{bus.if_ir, bus.if_npc});
    end
    if (bus.wb_we) regs[bus.wb_dr] = bus.wb_data;
  end

  // Monitor: compare the presented issue against the head of the expected queue.
  always @(negedge clk) begin
    bit   ev;
    ref_t r;
    if (mon_en) begin
      ev = exp_valid();
      check("de_valid", 16'(bus.de_valid), 16'(ev));
      check("if_ready", 16'(bus.if_ready), 16'((lat.size() == 0) || (ev && bus.de_ready)));
      if (ev && bus.de_valid) begin
        r = ref_decode(lat[0].ir);
        check("de_ir", bus.de_ir, lat[0].ir);
        check("de_npc", bus.de_npc, lat[0].npc);
        check("de_ld_reg", 16'(bus.de_ld_reg), 16'(r.w_reg));
        check("de_ld_cc", 16'(bus.de_ld_cc), 16'(r.w_cc));
        if (r.w_reg) check("de_dr", 16'(bus.de_dr), 16'(r.dr));
        if (r.r1) check("sr1_val", bus.de_sr1_val, opnd(r.s1));
        if (r.r2) check("sr2_val", bus.de_sr2_val, opnd(r.s2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid = 0; bus.if_ir = '0; bus.if_npc = '0; bus.flush = 0;
    bus.de_ready = 0; bus.wb_we = 0; bus.wb_dr = '0; bus.wb_data = '0; bus.wb_cc_we = 0;
  endtask

  task automatic fetch(input logic [15:0] ir, input logic [15:0] npc);
    bus.if_valid = 1; bus.if_ir = ir; bus.if_npc = npc;
  endtask

  task automatic wb(input logic [2:0] dr, input logic [15:0] data, input bit cc);
    bus.wb_we = 1; bus.wb_dr = dr; bus.wb_data = data; bus.wb_cc_we = cc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ref_t r;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    idle();
    rst = 1;
    tick(); tick();
    mon_en = 1;
    rst = 0;
    tick(); tick();
    @(negedge clk);
    check("rst de_valid", 16'(bus.de_valid), 16'h0);
    check("rst if_ready", 16'(bus.if_ready), 16'h1);
    check("rst de_ir", bus.de_ir, 16'h0);
    check("rst de_npc", bus.de_npc, 16'h0);

    // R3=5 then ADD R1,R2,R3
    tick(); idle(); wb(3, 16'h0005, 0);
    tick(); idle(); fetch(16'h1283, 16'h3002);
    tick(); idle();
    @(negedge clk);
    check("t1 de_valid", 16'(bus.de_valid), 16'h1);
    check("t1 sr2_val", bus.de_sr2_val, 16'h0005);
    check("t1 de_dr", 16'(bus.de_dr), 16'h1);
    check("t1 ld_cc", 16'(bus.de_ld_cc), 16'h1);

    // issue ADD R1, then dependent ADD R4,R1,#1 waits for writeback of R1
    tick(); idle(); bus.de_ready = 1; fetch(16'h1861, 16'h3004);
    tick(); idle();
    @(negedge clk);
    check("t2 stall de_valid", 16'(bus.de_valid), 16'h0);
    check("t2 stall if_ready", 16'(bus.if_ready), 16'h0);
    tick(); idle(); wb(1, 16'h0042, 1);
    @(negedge clk);
    check("t2 wb de_valid", 16'(bus.de_valid), 16'h1);
    check("t2 bypass sr1", bus.de_sr1_val, 16'h0042);
    tick(); idle(); bus.de_ready = 1;
    tick(); idle(); wb(4, 16'h0007, 1);

    // LDW R2 then BRz waits on CC; BR nzp=000 ignores pending CC
    tick(); idle(); fetch(16'h6440, 16'h3008);
    tick(); idle(); bus.de_ready = 1; fetch(16'h0403, 16'h300A);
    @(negedge clk);
    check("t3 ldw de_valid", 16'(bus.de_valid), 16'h1);
    tick(); idle();
    @(negedge clk);
    check("t3 brz stall", 16'(bus.de_valid), 16'h0);
    tick(); idle(); wb(2, 16'h1234, 1);
    @(negedge clk);
    check("t3 brz after cc wb", 16'(bus.de_valid), 16'h1);
    tick(); idle(); bus.de_ready = 1;
    tick(); idle(); bus.de_ready = 1; fetch(16'h1020, 16'h300C);
    tick(); idle(); bus.de_ready = 1; fetch(16'h0000, 16'h300E);
    tick(); idle();
    @(negedge clk);
    check("t3 br000 no stall", 16'(bus.de_valid), 16'h1);

    // STW R5 held, then flushed together with an incoming fetch
    tick(); idle(); bus.de_ready = 1; fetch(16'h7B80, 16'h3010);
    tick(); idle();
    @(negedge clk);
    check("t4 stw de_valid", 16'(bus.de_valid), 16'h1);
    tick(); idle(); bus.flush = 1; bus.de_ready = 1; fetch(16'h1200, 16'h3012);
    @(negedge clk);
    check("t4 flush de_valid", 16'(bus.de_valid), 16'h0);
    tick(); idle();
    @(negedge clk);
    check("t4 after flush de_valid", 16'(bus.de_valid), 16'h0);
    check("t4 after flush if_ready", 16'(bus.if_ready), 16'h1);
    tick(); idle(); fetch(16'h1200, 16'h3014);
    tick(); idle();
    @(negedge clk);
    check("t4 R0 still pending", 16'(bus.de_valid), 16'h0);
    tick(); idle(); bus.de_ready = 1; wb(0, 16'h0009, 1);
    tick(); idle(); wb(1, 16'h0011, 1);

    // JSR writes R7; consumer of R7 waits for it
    tick(); idle(); fetch(16'h4801, 16'h3016);
    tick(); idle();
    @(negedge clk);
    check("t5 jsr de_dr", 16'(bus.de_dr), 16'h7);
    check("t5 jsr ld_reg", 16'(bus.de_ld_reg), 16'h1);
    check("t5 jsr ld_cc", 16'(bus.de_ld_cc), 16'h0);
    tick(); idle(); bus.de_ready = 1; fetch(16'h11E0, 16'h3018);
    tick(); idle();
    @(negedge clk);
    check("t5 R7 stall", 16'(bus.de_valid), 16'h0);
    tick(); idle(); wb(7, 16'h3000, 0);
    @(negedge clk);
    check("t5 R7 wb de_valid", 16'(bus.de_valid), 16'h1);
    check("t5 R7 bypass", bus.de_sr1_val, 16'h3000);
    tick(); idle(); bus.de_ready = 1;
    tick(); idle(); wb(0, 16'h0001, 1);

    // backpressure holds the latch; reset then clears it
    tick(); idle(); fetch(16'h14C4, 16'h301A);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6 held de_valid", 16'(bus.de_valid), 16'h1);
      check("t6 held de_ir", bus.de_ir, 16'h14C4);
      tick(); idle();
    end
    rst = 1;
    tick(); idle(); rst = 0;
    @(negedge clk);
    check("t6 rst de_valid", 16'(bus.de_valid), 16'h0);
    check("t6 rst if_ready", 16'(bus.if_ready), 16'h1);
    check("t6 rst de_ir", bus.de_ir, 16'h0);
    tick(); idle(); fetch(16'h1AA0, 16'h301C);
    tick(); idle();
    @(negedge clk);
    check("t6 R2 not pending", 16'(bus.de_valid), 16'h1);

    // random traffic with in-order writebacks of issued instructions
    for (int n = 0; n < 3000; n++) begin
      tick(); idle();
      rst = ($urandom_range(0, 999) < 3);
      bus.if_valid = ($urandom_range(0, 9) < 6);
      bus.if_ir = 16'($urandom);
      bus.if_npc = 16'($urandom);
      bus.de_ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 99) < 3);
      bus.wb_data = 16'($urandom);
      if (inflight.size() > 0 && $urandom_range(0, 9) < 4) begin
        r = inflight.pop_front();
        bus.wb_we = r.w_reg;
        bus.wb_dr = r.dr;
        bus.wb_cc_we = r.w_cc;
      end else if ($urandom_range(0, 19) == 0) begin
        bus.wb_we = 1;
        bus.wb_dr = 3'($urandom);
      end
    end
    tick(); idle(); rst = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
